// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first,
// with valid/ready handshakes on both the operand and the result side.

module serial_adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module serial_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] sum,
   output logic         c_out
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [N-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            o_ready_q, o_ready_d;
   logic            o_valid_q, o_valid_d;
   logic            fa_s, fa_c;

   serial_adder_fa u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         cnt_q     <= '0;
         o_ready_q <= 1'b1;
         o_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         cnt_q     <= cnt_d;
         o_ready_q <= o_ready_d;
         o_valid_q <= o_valid_d;
      end
   end

   // Next-state, shift datapath and registered handshake flags
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Sum bits enter at the MSB, so after N shifts bit 0 is at index 0.
            sum_d        = sum_q >> 1;
            sum_d[N-1]   = fa_s;
            a_d          = a_q >> 1;
            b_d          = b_q >> 1;
            carry_d      = fa_c;
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               cout_d  = fa_c;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      o_ready_d = (state_d == ST_IDLE);
      o_valid_d = (state_d == ST_DONE);
   end

   assign o_ready = o_ready_q;
   assign o_valid = o_valid_q;
   assign sum     = sum_q;
   assign c_out   = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed N=8 cases, then random
// handshake traffic on N=1, 8 and 16 instances against an a+b+c_in model.

module tb_serial_adder;

   logic        clk;
   logic        rst_n;
   logic [15:0] a_v [3];
   logic [15:0] b_v [3];
   logic        c_v [3];
   logic        iv_v [3];
   logic        ir_v [3];
   logic        ordy_v [3];
   logic        ov_v [3];
   logic        cout_v [3];
   logic [0:0]  sum0;
   logic [7:0]  sum1;
   logic [15:0] sum2;
   logic [15:0] sum_v [3];

   int n_checks = 0;
   int n_fail   = 0;

   assign sum_v[0] = {15'd0, sum0};
   assign sum_v[1] = {8'd0, sum1};
   assign sum_v[2] = sum2;

   serial_adder #(.N(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .i_valid(iv_v[0]), .o_ready(ordy_v[0]),
      .a(a_v[0][0:0]), .b(b_v[0][0:0]), .c_in(c_v[0]), .o_valid(ov_v[0]),
      .i_ready(ir_v[0]), .sum(sum0), .c_out(cout_v[0])
   );

   serial_adder #(.N(8)) u_n8 (
      .clk(clk), .rst_n(rst_n), .i_valid(iv_v[1]), .o_ready(ordy_v[1]),
      .a(a_v[1][7:0]), .b(b_v[1][7:0]), .c_in(c_v[1]), .o_valid(ov_v[1]),
      .i_ready(ir_v[1]), .sum(sum1), .c_out(cout_v[1])
   );

   serial_adder #(.N(16)) u_n16 (
      .clk(clk), .rst_n(rst_n), .i_valid(iv_v[2]), .o_ready(ordy_v[2]),
      .a(a_v[2]), .b(b_v[2]), .c_in(c_v[2]), .o_valid(ov_v[2]),
      .i_ready(ir_v[2]), .sum(sum2), .c_out(cout_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one operand set to the N=8 instance; returns {c_out,sum} and the
   // number of cycles from the accept edge until o_valid.  Entered at a negedge.
   task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [8:0] res, output int lat);
      int w;
      a_v[1]  = {8'd0, a};
      b_v[1]  = {8'd0, b};
      c_v[1]  = c;
      iv_v[1] = 1'b1;
      w = 0;
      while (!ordy_v[1] && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      iv_v[1] = 1'b0;
      lat = 0;
      while (!ov_v[1] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      res = {cout_v[1], sum1};
   endtask

   task automatic handoff8(input string tag);
      ir_v[1] = 1'b1;
      @(negedge clk);
      ir_v[1] = 1'b0;
      check({tag, "_ov_after"}, {16'd0, ov_v[1]}, 17'd0);
      check({tag, "_rdy_after"}, {16'd0, ordy_v[1]}, 17'd1);
   endtask

   task automatic run_random(input int k, input int w, input int nvec);
      logic [16:0] exp_q [$];
      logic [16:0] mask, e, obs;
      int sent, recv, cyc;
      logic acc;
      string tag;
      tag  = $sformatf("rand_n%0d", w);
      mask = (17'd1 << w) - 17'd1;
      sent = 0;
      recv = 0;
      cyc  = 0;
      acc  = 1'b0;
      while (recv < nvec && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (acc) iv_v[k] = 1'b0;
         if (!iv_v[k] && sent < nvec && $urandom_range(0, 3) != 0) begin
            a_v[k]  = 16'($urandom) & mask[15:0];
            b_v[k]  = 16'($urandom) & mask[15:0];
            c_v[k]  = 1'($urandom);
            iv_v[k] = 1'b1;
         end
         ir_v[k] = ($urandom_range(0, 2) != 0);
         acc = iv_v[k] && ordy_v[k];
         if (acc) begin
            exp_q.push_back({1'b0, a_v[k]} + {1'b0, b_v[k]} + {16'd0, c_v[k]});
            sent++;
         end
         if (ov_v[k] && ir_v[k]) begin
            e   = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
            obs = ({16'd0, cout_v[k]} << w) | {1'b0, sum_v[k]};
            check(tag, obs, e);
            recv++;
         end
      end
      @(negedge clk);
      iv_v[k] = 1'b0;
      ir_v[k] = 1'b0;
      check({tag, "_recv"}, 17'(recv), 17'(nvec));
      check({tag, "_left"}, 17'(exp_q.size()), 17'd0);
   endtask

   initial begin
      logic [8:0] res;
      int lat;
      for (int i = 0; i < 3; i++) begin
         a_v[i] = 16'd0; b_v[i] = 16'd0; c_v[i] = 1'b0;
         iv_v[i] = 1'b0; ir_v[i] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", {16'd0, ordy_v[1]}, 17'd1);
      check("rst_valid", {16'd0, ov_v[1]}, 17'd0);
      check("rst_sum", {8'd0, cout_v[1], sum1}, 17'd0);
      rst_n = 1'b1;
      @(negedge clk);

      add8(8'd5, 8'd3, 1'b0, res, lat);
      check("add5_3", {8'd0, res}, 17'd8);
      check("add5_3_lat", 17'(lat), 17'd8);
      handoff8("add5_3");
      check("idle_hold_sum", {8'd0, cout_v[1], sum1}, 17'd8);

      add8(8'd255, 8'd1, 1'b0, res, lat);
      check("wrap", {8'd0, res}, 17'h100);
      handoff8("wrap");

      add8(8'd255, 8'd255, 1'b1, res, lat);
      check("max", {8'd0, res}, 17'h1FF);
      handoff8("max");

      // Backpressure with i_valid noise during RUN and DONE
      a_v[1] = 16'd100; b_v[1] = 16'd200; c_v[1] = 1'b0; iv_v[1] = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!ov_v[1] && lat < 50) begin
         iv_v[1] = ~iv_v[1];
         a_v[1]  = 16'($urandom) & 16'h00FF;
         b_v[1]  = 16'($urandom) & 16'h00FF;
         c_v[1]  = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      check("bp_lat", 17'(lat), 17'd8);
      for (int i = 0; i < 5; i++) begin
         iv_v[1] = ~iv_v[1];
         check("bp_valid", {16'd0, ov_v[1]}, 17'd1);
         check("bp_result", {8'd0, cout_v[1], sum1}, 17'd300);
         @(negedge clk);
      end
      iv_v[1] = 1'b0;
      check("bp_final", {8'd0, cout_v[1], sum1}, 17'd300);
      handoff8("bp");

      // Asynchronous reset in the middle of an add
      a_v[1] = 16'd200; b_v[1] = 16'd100; c_v[1] = 1'b0; iv_v[1] = 1'b1;
      @(negedge clk);
      iv_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {16'd0, ov_v[1]}, 17'd0);
      check("mid_rst_ready", {16'd0, ordy_v[1]}, 17'd1);
      check("mid_rst_sum", {8'd0, cout_v[1], sum1}, 17'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      add8(8'd7, 8'd9, 1'b0, res, lat);
      check("post_rst_add", {8'd0, res}, 17'd16);
      handoff8("post_rst");

      fork
         run_random(0, 1, 1000);
         run_random(1, 8, 1000);
         run_random(2, 16, 1000);
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
